// File: rtl/controlador_varredura_caixa_pkg.sv
// Shared types for the water-tank display scanner: level codes, scan states and
// the first column of every frame.
package controlador_varredura_caixa_pkg;

  localparam logic [2:0] NIVEL_VAZIO = 3'b000;
  localparam logic [2:0] NIVEL_BAIXO = 3'b001;
  localparam logic [2:0] NIVEL_MEDIO = 3'b010;
  localparam logic [2:0] NIVEL_ALTO  = 3'b011;
  localparam logic [2:0] NIVEL_ERRO  = 3'b100;

  localparam logic [4:0] COL_INICIO = 5'b00001;

  typedef enum logic {
    PARADO = 1'b0,
    VARRE  = 1'b1
  } estado_t;

  // Sensors fill from the bottom up; any gap in the {alto,medio,baixo} stack is a fault.
  function automatic logic [2:0] classifica_nivel(input logic [2:0] sens);
    logic [2:0] nivel;
    case (sens)
      3'b000:  nivel = NIVEL_VAZIO;
      3'b001:  nivel = NIVEL_BAIXO;
      3'b011:  nivel = NIVEL_MEDIO;
      3'b111:  nivel = NIVEL_ALTO;
      default: nivel = NIVEL_ERRO;
    endcase
    return nivel;
  endfunction

endpackage

// File: rtl/controlador_varredura_caixa_filtro_sensores.sv
// Synchronises the three level sensors and commits a new triple only after
// DEBOUNCE_FRAMES identical samples taken on the sample strobe (frame end).
module filtro_sensores
  import controlador_varredura_caixa_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       amostra_i,
  input  logic [2:0] sensores_i,
  output logic [2:0] sensores_o,
  output logic       commit_o,
  output logic [2:0] commit_dat_o
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_UM  = CW'(1);

  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    com_q, com_d;
  logic          commit;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    com_d  = com_q;
    commit = 1'b0;
    if (amostra_i) begin
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        cnt_d  = CNT_UM;
        if (DEBOUNCE_FRAMES == 1) begin
          commit = 1'b1;
          com_d  = sync2_q;
        end
      end else if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + CNT_UM;
        if (cnt_d == CNT_MAX) begin
          commit = 1'b1;
          com_d  = cand_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      com_q   <= '0;
    end else begin
      sync1_q <= sensores_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      com_q   <= com_d;
    end
  end

  assign sensores_o   = com_q;
  assign commit_o     = commit;
  assign commit_dat_o = com_d;

endmodule

// File: rtl/controlador_varredura_caixa.sv
// Scans the 5x7 tank display one column at a time, frames the debounced sensor
// triple so it only changes between frames, and classifies the tank level.
module controlador_varredura_caixa
  import controlador_varredura_caixa_pkg::*;
#(
  parameter int DIV_SCAN        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       alto_in,
  input  logic       medio_in,
  input  logic       baixo_in,
  output logic [4:0] col,
  output logic       alto,
  output logic       medio,
  output logic       baixo,
  output logic [2:0] nivel,
  output logic       erro,
  output logic       fim_quadro
);

  localparam int DW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV_SCAN - 1);
  localparam logic [DW-1:0] DIV_UM  = DW'(1);

  estado_t       estado_q, estado_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    col_q, col_d;
  logic [2:0]    nivel_q, nivel_d;
  logic          fim;
  logic [2:0]    sensores;
  logic          commit;
  logic [2:0]    commit_dat;

  assign fim = (estado_q == VARRE) && enable && (col_q == 5'b10000) && (div_q == DIV_MAX);

  always_comb begin
    estado_d = estado_q;
    div_d    = div_q;
    col_d    = col_q;
    if (estado_q == PARADO) begin
      div_d = '0;
      col_d = '0;
      if (enable) begin
        estado_d = VARRE;
        col_d    = COL_INICIO;
      end
    end else begin
      if (!enable) begin
        // Abort mid-frame; re-enable always restarts from the first column.
        estado_d = PARADO;
        div_d    = '0;
        col_d    = '0;
      end else if (div_q == DIV_MAX) begin
        div_d = '0;
        col_d = {col_q[3:0], col_q[4]};
      end else begin
        div_d = div_q + DIV_UM;
      end
    end
  end

  assign nivel_d = commit ? classifica_nivel(commit_dat) : nivel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= PARADO;
      div_q    <= '0;
      col_q    <= '0;
      nivel_q  <= NIVEL_VAZIO;
    end else begin
      estado_q <= estado_d;
      div_q    <= div_d;
      col_q    <= col_d;
      nivel_q  <= nivel_d;
    end
  end

  filtro_sensores #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_filtro (
    .clk         (clk),
    .reset       (reset),
    .amostra_i   (fim),
    .sensores_i  ({alto_in, medio_in, baixo_in}),
    .sensores_o  (sensores),
    .commit_o    (commit),
    .commit_dat_o(commit_dat)
  );

  assign col        = col_q;
  assign alto       = sensores[2];
  assign medio      = sensores[1];
  assign baixo      = sensores[0];
  assign nivel      = nivel_q;
  assign erro       = (nivel_q == NIVEL_ERRO);
  assign fim_quadro = fim;

endmodule
